// File: rtl/onewire_slave_if.sv
// rtl/onewire_slave_if.sv - byte-level handshake between the 1-Wire slave and its host logic
interface onewire_slave_if;
    logic       tx_mode;
    logic       tx_load;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_done;
    logic       reset_seen;
    logic       online;

    modport master (
        output tx_mode, tx_load, tx_byte,
        input  rx_byte, rx_valid, tx_done, reset_seen, online
    );

    modport slave (
        input  tx_mode, tx_load, tx_byte,
        output rx_byte, rx_valid, tx_done, reset_seen, online
    );
endinterface

// File: rtl/onewire_slave.sv
// rtl/onewire_slave.sv - 1-Wire slave: reset/presence, byte receive and byte transmit time slots
module onewire_slave #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic           clk,
    input  logic           rst,
    inout  wire            dq,
    onewire_slave_if.slave bus
);
    localparam int US      = CLK_FREQ / 1_000_000;
    localparam int T_RESET = 400 * US;
    localparam int T_SLOT  = 30 * US;
    localparam int T_PRES  = 120 * US;
    localparam int CW      = $clog2(T_RESET + 1);

    localparam logic [CW-1:0] RESET_LAST = CW'(T_RESET - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(T_SLOT - 1);
    localparam logic [CW-1:0] PRES_LAST  = CW'(T_PRES - 1);

    typedef enum logic [2:0] {
        WAIT_RESET, LOW_MEAS, PRES_WAIT, PRES_DRIVE,
        SLOT_IDLE, SLOT_RX, SLOT_TX, SLOT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic          dq_s1_q, dq_s1_d, dq_s2_q, dq_s2_d, dq_prev_q, dq_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_sr_q, rx_sr_d, rx_byte_q, rx_byte_d, tx_reg_q, tx_reg_d;
    logic          rx_valid_q, rx_valid_d, tx_done_q, tx_done_d;
    logic          reset_seen_q, reset_seen_d, online_q, online_d;
    logic          rose_q, rose_d, slot_tx_q, slot_tx_d, drive_bit_q, drive_bit_d;
    logic          fall, drive, reset_hit, slot_end;

    // Edges are taken on the synchronised level; our own drive only happens in
    // states that never look for a new falling edge.
    assign fall  = dq_prev_q & ~dq_s2_q;
    assign drive = (state_q == PRES_DRIVE) || ((state_q == SLOT_TX) && !drive_bit_q);
    assign dq    = drive ? 1'b0 : 1'bz;

    assign bus.rx_byte    = rx_byte_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.reset_seen = reset_seen_q;
    assign bus.online     = online_q;

    always_comb begin
        state_d      = state_q;
        dq_s1_d      = dq;
        dq_s2_d      = dq_s1_q;
        dq_prev_d    = dq_s2_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sr_d      = rx_sr_q;
        rx_byte_d    = rx_byte_q;
        tx_reg_d     = tx_reg_q;
        rx_valid_d   = 1'b0;
        tx_done_d    = 1'b0;
        reset_seen_d = 1'b0;
        online_d     = online_q;
        rose_d       = rose_q;
        slot_tx_d    = slot_tx_q;
        drive_bit_d  = drive_bit_q;
        reset_hit    = 1'b0;
        slot_end     = 1'b0;

        case (state_q)
            WAIT_RESET: begin
                if (fall) begin
                    state_d = LOW_MEAS;
                    cnt_d   = '0;
                end
            end
            LOW_MEAS: begin
                cnt_d = cnt_q + 1'b1;
                if (dq_s2_q) state_d = online_q ? SLOT_IDLE : WAIT_RESET;
                else if (cnt_q == RESET_LAST) reset_hit = 1'b1;
            end
            PRES_WAIT: begin
                if (!rose_q) begin
                    if (dq_s2_q) begin
                        rose_d = 1'b1;
                        cnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SLOT_LAST) begin
                        state_d = PRES_DRIVE;
                        cnt_d   = '0;
                    end
                end
            end
            PRES_DRIVE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PRES_LAST) begin
                    state_d  = SLOT_IDLE;
                    online_d = 1'b1;
                end
            end
            SLOT_IDLE: begin
                if (fall) begin
                    cnt_d       = '0;
                    slot_tx_d   = bus.tx_mode;
                    drive_bit_d = tx_reg_q[bit_cnt_q];
                    state_d     = bus.tx_mode ? SLOT_TX : SLOT_RX;
                end
            end
            SLOT_RX: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SLOT_LAST) begin
                    rx_sr_d[bit_cnt_q] = dq_s2_q;
                    state_d            = SLOT_HIGH;
                end
            end
            SLOT_TX: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SLOT_LAST) state_d = SLOT_HIGH;
            end
            SLOT_HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (dq_s2_q) begin
                    slot_end = 1'b1;
                    state_d  = SLOT_IDLE;
                end else if (cnt_q == RESET_LAST) begin
                    reset_hit = 1'b1;
                end
            end
            default: state_d = WAIT_RESET;
        endcase

        // A load arriving with the slot end restarts the byte instead of advancing it.
        if (slot_end && !bus.tx_load) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
                if (slot_tx_q) begin
                    tx_done_d = 1'b1;
                end else begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = rx_sr_q;
                end
            end
        end

        if (reset_hit) begin
            reset_seen_d = 1'b1;
            bit_cnt_d    = '0;
            rx_sr_d      = '0;
            rose_d       = 1'b0;
            state_d      = PRES_WAIT;
        end

        if (bus.tx_load) begin
            tx_reg_d  = bus.tx_byte;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_RESET;
            dq_s1_q      <= 1'b1;
            dq_s2_q      <= 1'b1;
            dq_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            rx_byte_q    <= '0;
            tx_reg_q     <= '0;
            rx_valid_q   <= 1'b0;
            tx_done_q    <= 1'b0;
            reset_seen_q <= 1'b0;
            online_q     <= 1'b0;
            rose_q       <= 1'b0;
            slot_tx_q    <= 1'b0;
            drive_bit_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            dq_s1_q      <= dq_s1_d;
            dq_s2_q      <= dq_s2_d;
            dq_prev_q    <= dq_prev_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            rx_byte_q    <= rx_byte_d;
            tx_reg_q     <= tx_reg_d;
            rx_valid_q   <= rx_valid_d;
            tx_done_q    <= tx_done_d;
            reset_seen_q <= reset_seen_d;
            online_q     <= online_d;
            rose_q       <= rose_d;
            slot_tx_q    <= slot_tx_d;
            drive_bit_q  <= drive_bit_d;
        end
    end
endmodule

// File: tb/tb_onewire_slave.sv
// tb/tb_onewire_slave.sv - randomized host-side bench for onewire_slave with event scoreboard
`timescale 1ns/1ps
module tb_onewire_slave;
    localparam int CLK_FREQ = 5_000_000;
    localparam int US       = CLK_FREQ / 1_000_000;

    localparam int EV_RST = 0;
    localparam int EV_RX  = 1;
    localparam int EV_TXD = 2;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_low = 1'b0;
    wire  dq;

    pullup (dq);
    assign dq = host_low ? 1'b0 : 1'bz;

    onewire_slave_if ow_if ();

    onewire_slave #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk (clk),
        .rst (rst),
        .dq  (dq),
        .bus (ow_if.slave)
    );

    always #100 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    ev_t  exp_q[$];
    int   cycle = 0;
    int   rst_cycle = 0;
    int   self_low = 0;

    // Host-visible model of the slave: bit position, partial byte, tx byte, online.
    int         m_pos = 0;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] m_tx = 8'h00;
    bit         m_online = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int data, input string name);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: got event kind %0d data 0x%0h expected none", name, kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                fails++;
                $display("FAIL %s: got kind %0d data 0x%0h expected kind %0d data 0x%0h",
                         name, kind, data, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dq === 1'b0 && !host_low) self_low++;
            if (ow_if.reset_seen === 1'b1) begin
                rst_cycle = cycle;
                pop_check(EV_RST, 0, "reset_seen");
            end
            if (ow_if.rx_valid === 1'b1) pop_check(EV_RX, int'(ow_if.rx_byte), "rx_byte");
            if (ow_if.tx_done === 1'b1) pop_check(EV_TXD, 0, "tx_done");
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic wait_us(input int n);
        repeat (n * US) @(posedge clk);
        #1;
    endtask

    task automatic host_write_bit(input bit b, input int low_us, input bit toggle_mode);
        if (m_online) begin
            m_rx[m_pos] = b;
            if (m_pos == 7) push_ev(EV_RX, int'(m_rx));
            m_pos = (m_pos + 1) % 8;
        end
        host_low = 1'b1;
        wait_us(3);
        if (toggle_mode) ow_if.tx_mode = 1'b1;
        wait_us(low_us - 3);
        host_low = 1'b0;
        wait_us((low_us < 60) ? 72 - low_us : 12);
        ow_if.tx_mode = 1'b0;
    endtask

    task automatic host_write_byte(input logic [7:0] v);
        int tog;
        tog = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++)
            host_write_bit(v[i], v[i] ? 6 : 60, i == tog);
    endtask

    task automatic host_read_byte(input int nbytes);
        logic [7:0] got, want;
        for (int k = 0; k < nbytes; k++) begin
            for (int i = 0; i < 8; i++) begin
                want[i] = m_tx[m_pos];
                if (m_pos == 7) push_ev(EV_TXD, 0);
                m_pos = (m_pos + 1) % 8;
                host_low = 1'b1;
                wait_us(2);
                host_low = 1'b0;
                wait_us(13);
                got[i] = dq;
                wait_us(62);
            end
            check("host_read_byte", 32'(got), 32'(want));
        end
    endtask

    task automatic host_reset(input int low_us, input bit pres_checks);
        int fall_cycle;
        push_ev(EV_RST, 0);
        m_pos = 0;
        m_rx  = 8'h00;
        host_low = 1'b1;
        fall_cycle = cycle;
        wait_us(low_us);
        host_low = 1'b0;
        m_online = 1'b1;
        check("reset_seen_latency", 32'((rst_cycle - fall_cycle >= 400 * US) &&
                                        (rst_cycle - fall_cycle <= 400 * US + 5)), 32'd1);
        if (pres_checks) begin
            wait_us(15);
            check("presence_not_early", 32'(dq), 32'd1);
            wait_us(45);
            check("presence_low", 32'(dq), 32'd0);
            wait_us(140);
            check("presence_released", 32'(dq), 32'd1);
            check("online_after_presence", 32'(ow_if.online), 32'd1);
        end
    endtask

    initial begin
        ow_if.tx_mode = 1'b0;
        ow_if.tx_load = 1'b0;
        ow_if.tx_byte = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_dq", 32'(dq), 32'd1);
        check("reset_rx_byte", 32'(ow_if.rx_byte), 32'd0);
        check("reset_online", 32'(ow_if.online), 32'd0);
        check("reset_pulses", 32'({ow_if.rx_valid, ow_if.tx_done, ow_if.reset_seen}), 32'd0);
        rst = 1'b0;
        wait_us(5);

        // Slots before any host reset must be ignored.
        self_low = 0;
        host_write_byte(8'($urandom_range(0, 255)));
        check("prereset_never_driven", 32'(self_low), 32'd0);
        check("prereset_offline", 32'(ow_if.online), 32'd0);

        host_reset(480, 1'b1);

        host_write_byte(8'hA5);
        for (int n = 0; n < 3; n++) host_write_byte(8'($urandom_range(0, 255)));

        @(posedge clk) #1;
        ow_if.tx_byte = 8'h3C;
        ow_if.tx_load = 1'b1;
        @(posedge clk) #1;
        ow_if.tx_load = 1'b0;
        m_tx  = 8'h3C;
        m_pos = 0;
        ow_if.tx_mode = 1'b1;
        wait_us(2);
        host_read_byte(2);
        @(posedge clk) #1;
        ow_if.tx_byte = 8'($urandom_range(0, 255));
        m_tx = ow_if.tx_byte;
        m_pos = 0;
        ow_if.tx_load = 1'b1;
        @(posedge clk) #1;
        ow_if.tx_load = 1'b0;
        host_read_byte(1);
        ow_if.tx_mode = 1'b0;
        wait_us(2);

        // A long-but-short-of-reset low is an ordinary 0 slot; a 450 us low mid-byte is a reset.
        host_write_bit(1'b0, 200, 1'b0);
        host_write_bit(1'($urandom_range(0, 1)), 60, 1'b0);
        host_write_bit(1'b1, 6, 1'b0);
        host_reset(450, 1'b1);
        host_write_byte(8'($urandom_range(0, 255)));

        // Asynchronous reset while the presence pulse is being driven.
        host_reset(480, 1'b0);
        wait_us(60);
        check("presence_active_before_rst", 32'(dq), 32'd0);
        #50;
        rst = 1'b1;
        m_online = 1'b0;
        m_pos = 0;
        m_tx  = 8'h00;
        #1;
        check("rst_releases_dq", 32'(dq), 32'd1);
        check("rst_online", 32'(ow_if.online), 32'd0);
        check("rst_rx_byte", 32'(ow_if.rx_byte), 32'd0);
        check("rst_pulses", 32'({ow_if.rx_valid, ow_if.tx_done, ow_if.reset_seen}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_us(5);
        self_low = 0;
        host_write_byte(8'h5A);
        check("post_rst_never_driven", 32'(self_low), 32'd0);

        wait_us(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
